// File: rtl/eret_sequencer.sv
// rtl/eret_sequencer.sv - return-from-exception sequencer that restores SR/MODE and redirects fetch to EPC
//
// Purpose:
//   On a kernel-mode ERET this block freezes the pipeline and walks the SPR
//   file over its single read/write port:
//     read EPC -> read ESR -> write SR -> read EMODE -> write MODE -> redirect.
//   A user-mode ERET is rejected with a one-cycle illegal_eret pulse.
//   A misaligned restored EPC is reported with eret_fault instead of a
//   pc_load. An interrupt (jisr) at any point abandons the walk; writes
//   already committed stay committed.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   instr           instruction in execute stage
//   instr_valid     instr is live this cycle
//   mode            current MODE SPR (0 = kernel, 1 = user)
//   jisr            interrupt taken this cycle
//   spr_rd_data     SPR read data, combinational from spr_rd_sel
//   spr_rd_sel      SPR read select
//   spr_wr_en       SPR write strobe
//   spr_wr_sel      SPR write select
//   spr_wr_data     SPR write data
//   stall           freeze fetch/decode/execute
//   pc_load         one-cycle pulse: load pc_target into PC
//   pc_target       restored EPC (registered)
//   illegal_eret    one-cycle pulse: ERET attempted in user mode
//   eret_fault      one-cycle pulse: restored EPC misaligned
//   busy            sequencer is mid-walk (not IDLE)
//   eret_cnt        completed-ERET counter, wraps 255 -> 0

module eret_sequencer #(
  parameter logic [5:0] ERET_FUNCT = 6'b011000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] mode,
  input  logic        jisr,
  input  logic [31:0] spr_rd_data,
  output logic [2:0]  spr_rd_sel,
  output logic        spr_wr_en,
  output logic [2:0]  spr_wr_sel,
  output logic [31:0] spr_wr_data,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        illegal_eret,
  output logic        eret_fault,
  output logic        busy,
  output logic [7:0]  eret_cnt
);

  // SPR select map
  localparam logic [2:0] SEL_SR    = 3'd0;
  localparam logic [2:0] SEL_ESR   = 3'd1;
  localparam logic [2:0] SEL_EPC   = 3'd3;
  localparam logic [2:0] SEL_MODE  = 3'd6;
  localparam logic [2:0] SEL_EMODE = 3'd7;

  localparam logic [5:0] OPC_SPECIAL = 6'b010000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_EPC   = 3'd1,
    RD_ESR   = 3'd2,
    WR_SR    = 3'd3,
    RD_EMODE = 3'd4,
    WR_MODE  = 3'd5,
    REDIRECT = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] epc_q;
  logic [31:0] esr_q;
  logic [31:0] emode_q;
  logic [7:0]  cnt_q;

  logic        is_eret;
  logic        start;
  logic        epc_aligned;

  // Only the opcode and funct fields take part in the decode.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  assign is_eret     = instr_valid && (instr[31:26] == OPC_SPECIAL) &&
                       (instr[5:0] == ERET_FUNCT);
  assign start       = is_eret && (mode == 32'd0) && !jisr;
  assign epc_aligned = (epc_q[1:0] == 2'b00);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (start) begin
        state_next = RD_EPC;
      end
    end else if (jisr) begin
      // Interrupt entry takes over the SPRs; drop the walk immediately.
      state_next = IDLE;
    end else begin
      unique case (state)
        RD_EPC:   state_next = RD_ESR;
        RD_ESR:   state_next = WR_SR;
        WR_SR:    state_next = RD_EMODE;
        RD_EMODE: state_next = WR_MODE;
        WR_MODE:  state_next = REDIRECT;
        REDIRECT: state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  // Reset suppresses every combinational output in the cycle it is
  // asserted, so a reset landing on WR_SR/WR_MODE never commits a write.
  // An aborting jisr suppresses the write/redirect side effects but the
  // read select is left alone since reads have no side effects.
  always_comb begin
    spr_rd_sel   = 3'd0;
    spr_wr_en    = 1'b0;
    spr_wr_sel   = 3'd0;
    spr_wr_data  = 32'd0;
    stall        = 1'b0;
    pc_load      = 1'b0;
    illegal_eret = 1'b0;
    eret_fault   = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          stall        = start;
          illegal_eret = is_eret && (mode == 32'd1);
        end
        RD_EPC: begin
          stall      = 1'b1;
          spr_rd_sel = SEL_EPC;
        end
        RD_ESR: begin
          stall      = 1'b1;
          spr_rd_sel = SEL_ESR;
        end
        WR_SR: begin
          stall = 1'b1;
          if (!jisr) begin
            spr_wr_en   = 1'b1;
            spr_wr_sel  = SEL_SR;
            spr_wr_data = esr_q;
          end
        end
        RD_EMODE: begin
          stall      = 1'b1;
          spr_rd_sel = SEL_EMODE;
        end
        WR_MODE: begin
          stall = 1'b1;
          if (!jisr) begin
            spr_wr_en   = 1'b1;
            spr_wr_sel  = SEL_MODE;
            spr_wr_data = emode_q;
          end
        end
        REDIRECT: begin
          stall = 1'b1;
          if (!jisr) begin
            pc_load    = epc_aligned;
            eret_fault = !epc_aligned;
          end
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign pc_target = epc_q;
  assign eret_cnt  = cnt_q;

  // ---------------------------------------------------------------------
  // Captured SPR values and completion counter
  // ---------------------------------------------------------------------
  // A capture in a cycle that jisr aborts is discarded, so pc_target keeps
  // the last EPC of a walk that actually got past RD_EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q   <= 32'd0;
      esr_q   <= 32'd0;
      emode_q <= 32'd0;
      cnt_q   <= 8'd0;
    end else if (!jisr) begin
      unique case (state)
        RD_EPC:   epc_q   <= spr_rd_data;
        RD_ESR:   esr_q   <= spr_rd_data;
        RD_EMODE: emode_q <= spr_rd_data;
        REDIRECT: begin
          if (epc_aligned) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eret_sequencer.sv
// tb/tb_eret_sequencer.sv - self-checking bench for eret_sequencer against a step-counter model

module tb_eret_sequencer;

  localparam logic [31:0] ERET = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] mode;
  logic        jisr;
  logic [31:0] spr_rd_data;
  logic [2:0]  spr_rd_sel;
  logic        spr_wr_en;
  logic [2:0]  spr_wr_sel;
  logic [31:0] spr_wr_data;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        illegal_eret;
  logic        eret_fault;
  logic        busy;
  logic [7:0]  eret_cnt;

  always #5 clk = ~clk;

  eret_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mode(mode), .jisr(jisr), .spr_rd_data(spr_rd_data),
    .spr_rd_sel(spr_rd_sel), .spr_wr_en(spr_wr_en), .spr_wr_sel(spr_wr_sel),
    .spr_wr_data(spr_wr_data), .stall(stall), .pc_load(pc_load),
    .pc_target(pc_target), .illegal_eret(illegal_eret),
    .eret_fault(eret_fault), .busy(busy), .eret_cnt(eret_cnt)
  );

  // Bench-side SPR file; updated only with the writes the model expects.
  logic [31:0] spr_m [8];
  assign spr_rd_data = spr_m[spr_rd_sel];

  // Model: k counts cycles since ERET acceptance (0 = idle, 1..6 = walk step).
  int          m_k;
  logic [31:0] m_epc, m_esr, m_emode;
  logic [7:0]  m_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Last observed DUT outputs, for literal checks in directed tests.
  logic        o_we, o_stall, o_pl, o_fa, o_il, o_busy;
  logic [2:0]  o_ws;
  logic [31:0] o_wd, o_tgt;
  logic [7:0]  o_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] md, input logic j);
    logic        is_er;
    logic [2:0]  e_rd, e_ws;
    logic        e_we, e_st, e_pl, e_fa, e_il;
    logic [31:0] e_wd;
    @(negedge clk);
    rst = r; instr_valid = v; instr = ins; mode = md; jisr = j;
    #1;
    is_er = v && (ins[31:26] == 6'b010000) && (ins[5:0] == 6'b011000);
    e_rd = 3'd0; e_ws = 3'd0; e_wd = 32'd0;
    e_we = 1'b0; e_st = 1'b0; e_pl = 1'b0; e_fa = 1'b0; e_il = 1'b0;
    if (!r) begin
      if (m_k == 0) begin
        e_st = is_er && (md == 32'd0) && !j;
        e_il = is_er && (md == 32'd1);
      end else begin
        e_st = 1'b1;
        case (m_k)
          1: e_rd = 3'd3;
          2: e_rd = 3'd1;
          4: e_rd = 3'd7;
          3: if (!j) begin e_we = 1'b1; e_ws = 3'd0; e_wd = m_esr; end
          5: if (!j) begin e_we = 1'b1; e_ws = 3'd6; e_wd = m_emode; end
          6: if (!j) begin
               if (m_epc[1:0] == 2'b00) e_pl = 1'b1;
               else e_fa = 1'b1;
             end
          default: ;
        endcase
      end
    end
    chk("spr_rd_sel", 32'(spr_rd_sel), 32'(e_rd));
    chk("spr_wr_en", 32'(spr_wr_en), 32'(e_we));
    chk("spr_wr_sel", 32'(spr_wr_sel), 32'(e_ws));
    chk("spr_wr_data", spr_wr_data, e_wd);
    chk("stall", 32'(stall), 32'(e_st));
    chk("pc_load", 32'(pc_load), 32'(e_pl));
    chk("eret_fault", 32'(eret_fault), 32'(e_fa));
    chk("illegal_eret", 32'(illegal_eret), 32'(e_il));
    chk("busy", 32'(busy), 32'(m_k != 0));
    chk("pc_target", pc_target, m_epc);
    chk("eret_cnt", 32'(eret_cnt), 32'(m_cnt));
    o_we = spr_wr_en; o_ws = spr_wr_sel; o_wd = spr_wr_data; o_stall = stall;
    o_pl = pc_load; o_fa = eret_fault; o_il = illegal_eret; o_busy = busy;
    o_tgt = pc_target; o_cnt = eret_cnt;
    // advance the model
    if (r) begin
      m_k = 0; m_epc = 0; m_esr = 0; m_emode = 0; m_cnt = 0;
    end else if (m_k == 0) begin
      if (e_st) m_k = 1;
    end else if (j) begin
      m_k = 0;
    end else begin
      case (m_k)
        1: m_epc = spr_m[3];
        2: m_esr = spr_m[1];
        4: m_emode = spr_m[7];
        6: if (m_epc[1:0] == 2'b00) m_cnt = m_cnt + 8'd1;
        default: ;
      endcase
      m_k = (m_k == 6) ? 0 : m_k + 1;
    end
    @(posedge clk);
    #1;
    if (e_we) spr_m[e_ws] = e_wd;
  endtask

  initial begin
    int n_st, n_we, n_pl;
    logic [31:0] tmp, ins, md;
    for (int i = 0; i < 8; i++) spr_m[i] = 32'd0;
    rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; mode = 32'd0; jisr = 1'b0;
    m_k = 0; m_epc = 0; m_esr = 0; m_emode = 0; m_cnt = 0;

    // Reset state
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_tgt", o_tgt, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);

    // Kernel ERET
    spr_m[3] = 32'h0000_1000; spr_m[1] = 32'h0000_00FF; spr_m[7] = 32'd1;
    n_st = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i < 7, ERET, 32'd0, 1'b0);
      n_st += int'(o_stall);
      if (i == 3) begin
        chk("k_sr_we", 32'(o_we), 32'd1);
        chk("k_sr_sel", 32'(o_ws), 32'd0);
        chk("k_sr_data", o_wd, 32'h0000_00FF);
      end
      if (i == 5) begin
        chk("k_mode_sel", 32'(o_ws), 32'd6);
        chk("k_mode_data", o_wd, 32'd1);
      end
      if (i == 6) begin
        chk("k_pc_load", 32'(o_pl), 32'd1);
        chk("k_pc_target", o_tgt, 32'h0000_1000);
      end
      if (i == 7) chk("k_cnt", 32'(o_cnt), 32'd1);
    end
    chk("k_stall_cycles", 32'(n_st), 32'd7);

    // User-mode ERET
    step(1'b0, 1'b1, ERET, 32'd1, 1'b0);
    chk("u_illegal", 32'(o_il), 32'd1);
    chk("u_stall", 32'(o_stall), 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd1, 1'b0);
    chk("u_illegal_off", 32'(o_il), 32'd0);
    chk("u_busy", 32'(o_busy), 32'd0);

    // Misaligned EPC
    spr_m[3] = 32'h0000_1002;
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i == 0, ERET, 32'd0, 1'b0);
      n_we += int'(o_we);
      if (i == 6) begin
        chk("m_fault", 32'(o_fa), 32'd1);
        chk("m_pc_load", 32'(o_pl), 32'd0);
      end
    end
    chk("m_writes", 32'(n_we), 32'd2);
    chk("m_cnt", 32'(o_cnt), 32'd1);

    // jisr at T+4
    spr_m[3] = 32'h0000_2000;
    n_we = 0; n_pl = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, i == 0, ERET, 32'd0, i == 4);
      n_we += int'(o_we); n_pl += int'(o_pl);
      if (i == 5) chk("j_idle", 32'(o_busy), 32'd0);
    end
    chk("j_writes", 32'(n_we), 32'd1);
    chk("j_pc_load", 32'(n_pl), 32'd0);

    // rst at T+3
    for (int i = 0; i < 5; i++) begin
      step(i == 3, i == 0, ERET, 32'd0, 1'b0);
      if (i == 3) chk("r_no_sr_write", 32'(o_we), 32'd0);
      if (i == 4) begin
        chk("r_busy", 32'(o_busy), 32'd0);
        chk("r_cnt", 32'(o_cnt), 32'd0);
        chk("r_tgt", o_tgt, 32'd0);
      end
    end

    // 256 back-to-back ERETs: counter wraps
    spr_m[3] = 32'h0000_3000;
    n_pl = 0;
    for (int i = 0; i < 256 * 7; i++) begin
      step(1'b0, 1'b1, ERET, 32'd0, 1'b0);
      n_pl += int'(o_pl);
      if (i == 7) begin
        chk("b2b_accept_stall", 32'(o_stall), 32'd1);
        chk("b2b_accept_busy", 32'(o_busy), 32'd0);
      end
    end
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("wrap_loads", 32'(n_pl), 32'd256);
    chk("wrap_cnt", 32'(o_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (m_k == 0 && $urandom_range(0, 3) == 0) begin
        tmp = $urandom;
        if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
        spr_m[3] = tmp;
        spr_m[1] = $urandom;
        spr_m[7] = 32'($urandom_range(0, 1));
      end
      ins = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        ins[31:26] = 6'b010000;
        ins[5:0] = 6'b011000;
      end
      case ($urandom_range(0, 4))
        0, 1, 2: md = 32'd0;
        3: md = 32'd1;
        default: md = $urandom;
      endcase
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0, ins, md,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
